// File: rtl/cycle_sequencer.sv
// Instruction cycle sequencer: reset, fetch, execute and interrupt-entry timing
// for the decoder. Optional edge-triggered NMI support is enabled by NMI_SEQ_EN.
module cycle_sequencer (
  input  logic       clk,
  input  logic       clr,
  input  logic       rdy,
  input  logic [7:0] din,
  input  logic       dec_last,
  input  logic       dec_skip,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       iflag,
  output logic [7:0] inst,
  output logic [2:0] cyc,
  output logic [1:0] state,
  output logic       ir_ld,
  output logic       pc_inc,
  output logic [1:0] vec_sel,
  output logic       halt
);

  typedef enum logic [1:0] {
    S_RST   = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_INT   = 2'b11
  } seq_state_t;

  seq_state_t st_q, st_d;
  logic [2:0] cyc_q, cyc_d;
  logic [7:0] inst_q, inst_d;
  logic [1:0] vec_q, vec_d;
  logic       halt_q, halt_d;
  logic       nmi_pend;
  logic       nmi_clr;
  logic       int_pend;
  logic [1:0] int_vec;
  logic [3:0] adv;

  assign int_pend = nmi_pend | (~irq_n & ~iflag);
  assign int_vec  = nmi_pend ? 2'b01 : 2'b11;
  // One bit wider than cyc so an advance past 7 shows up as adv[3].
  assign adv      = {1'b0, cyc_q} + (dec_skip ? 4'd2 : 4'd1);

  always_comb begin
    st_d    = st_q;
    cyc_d   = cyc_q;
    inst_d  = inst_q;
    vec_d   = vec_q;
    halt_d  = halt_q;
    ir_ld   = 1'b0;
    pc_inc  = 1'b0;
    nmi_clr = 1'b0;
    if (rdy && !halt_q) begin
      case (st_q)
        S_RST: begin
          if (cyc_q == 3'd6) begin
            st_d  = S_FETCH;
            cyc_d = '0;
          end else begin
            cyc_d = cyc_q + 3'd1;
          end
        end
        S_FETCH: begin
          ir_ld  = clr;
          pc_inc = clr;
          inst_d = din;
          st_d   = S_EXEC;
          cyc_d  = 3'd1;
        end
        S_EXEC: begin
          if (dec_last) begin
            cyc_d = '0;
            if (int_pend) begin
              st_d    = S_INT;
              inst_d  = '0;
              vec_d   = int_vec;
              nmi_clr = nmi_pend;
            end else begin
              st_d = S_FETCH;
            end
          end else if (adv[3]) begin
            halt_d = 1'b1;
          end else begin
            cyc_d = adv[2:0];
          end
        end
        S_INT: begin
          if (cyc_q == 3'd6) begin
            st_d  = S_FETCH;
            cyc_d = '0;
            vec_d = '0;
          end else begin
            cyc_d = cyc_q + 3'd1;
          end
        end
        default: st_d = S_RST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      st_q   <= S_RST;
      cyc_q  <= '0;
      inst_q <= '0;
      vec_q  <= 2'b10;
      halt_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cyc_q  <= cyc_d;
      inst_q <= inst_d;
      vec_q  <= vec_d;
      halt_q <= halt_d;
    end
  end

`ifdef NMI_SEQ_EN
  logic nmi_q;

  // Sampled every clock independent of rdy; a fresh edge beats the entry clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      nmi_q    <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      nmi_q <= nmi_n;
      if (nmi_q && !nmi_n)
        nmi_pend <= 1'b1;
      else if (nmi_clr)
        nmi_pend <= 1'b0;
    end
  end
`else
  logic unused_nmi;

  assign nmi_pend   = 1'b0;
  assign unused_nmi = nmi_n ^ nmi_clr;
`endif

  assign state   = st_q;
  assign cyc     = cyc_q;
  assign inst    = inst_q;
  assign vec_sel = vec_q;
  assign halt    = halt_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Randomized and directed bench for cycle_sequencer against a behavioural model.
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       clr, rdy, dec_last, dec_skip, irq_n, nmi_n, iflag;
  logic [7:0] din;
  logic [7:0] inst;
  logic [2:0] cyc;
  logic [1:0] state, vec_sel;
  logic       ir_ld, pc_inc, halt;

  int total = 0;
  int bad   = 0;

  localparam int M_RST = 0, M_FETCH = 1, M_EXEC = 2, M_INT = 3;

  // Reference model of the sequencer's architectural state.
  int   m_mode, m_cyc;
  logic [7:0] m_inst;
  logic [1:0] m_vec;
  bit   m_halt, m_pend, m_nmi_prev;
  logic [1:0] int_vec;

  always #5 clk = ~clk;

  cycle_sequencer dut (
    .clk(clk), .clr(clr), .rdy(rdy), .din(din), .dec_last(dec_last),
    .dec_skip(dec_skip), .irq_n(irq_n), .nmi_n(nmi_n), .iflag(iflag),
    .inst(inst), .cyc(cyc), .state(state), .ir_ld(ir_ld), .pc_inc(pc_inc),
    .vec_sel(vec_sel), .halt(halt)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RST; m_cyc = 0; m_inst = 8'h00; m_vec = 2'b10;
    m_halt = 0; m_pend = 0; m_nmi_prev = 1;
  endtask

  task automatic model_step();
    bit fell, take_clear;
    int nxt;
    if (!clr) begin
      model_reset();
      return;
    end
`ifdef NMI_SEQ_EN
    fell = m_nmi_prev && !nmi_n;
`else
    fell = 0;
`endif
    take_clear = 0;
    if (rdy && !m_halt) begin
      if (m_mode == M_RST || m_mode == M_INT) begin
        if (m_cyc == 6) begin
          if (m_mode == M_INT) m_vec = 2'b00;
          m_mode = M_FETCH; m_cyc = 0;
        end else m_cyc++;
      end else if (m_mode == M_FETCH) begin
        m_inst = din; m_mode = M_EXEC; m_cyc = 1;
      end else if (dec_last) begin
        m_cyc = 0;
        if (m_pend || (!irq_n && !iflag)) begin
          m_vec = m_pend ? 2'b01 : 2'b11;
          take_clear = m_pend;
          m_inst = 8'h00; m_mode = M_INT;
        end else m_mode = M_FETCH;
      end else begin
        nxt = m_cyc + (dec_skip ? 2 : 1);
        if (nxt > 7) m_halt = 1;
        else m_cyc = nxt;
      end
    end
    if (fell) m_pend = 1;
    else if (take_clear) m_pend = 0;
    m_nmi_prev = nmi_n;
  endtask

  // One clock: strobes checked mid-cycle, registers checked just after the edge.
  task automatic tick();
    bit exp_strobe;
    @(negedge clk);
    exp_strobe = clr && rdy && !m_halt && (m_mode == M_FETCH);
    check("ir_ld", {7'd0, ir_ld}, {7'd0, exp_strobe});
    check("pc_inc", {7'd0, pc_inc}, {7'd0, exp_strobe});
    @(posedge clk);
    model_step();
    #1;
    check("state", {6'd0, state}, 8'(m_mode));
    check("cyc", {5'd0, cyc}, 8'(m_cyc));
    check("inst", inst, m_inst);
    check("vec_sel", {6'd0, vec_sel}, {6'd0, m_vec});
    check("halt", {7'd0, halt}, {7'd0, m_halt});
  endtask

  task automatic quiet();
    clr = 1; rdy = 1; dec_last = 0; dec_skip = 0; irq_n = 1; nmi_n = 1; iflag = 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // From RST (cyc 0) through the fetch of opcode op.
  task automatic boot_fetch(input logic [7:0] op);
    quiet(); din = op;
    run(8);
  endtask

  initial begin
    quiet(); clr = 0; din = 8'h00;
    @(posedge clk);
    model_reset();
    #1;
    tick();
    check("rst_state", {6'd0, state}, 8'd0);
    check("rst_vec", {6'd0, vec_sel}, 8'd2);

    // Power-up sequence, then skip and dec_last handling.
    boot_fetch(8'hEA);
    check("boot_inst", inst, 8'hEA);
    check("boot_cyc", {5'd0, cyc}, 8'd1);
    tick();
    dec_skip = 1; tick();
    check("skip_cyc", {5'd0, cyc}, 8'd4);
    dec_skip = 1; dec_last = 1; tick();
    check("last_fetch", {6'd0, state}, 8'd1);

    // Unmasked IRQ enters INT; masked IRQ does not.
    quiet(); din = 8'h4C; tick();
    dec_last = 1; irq_n = 0; iflag = 0; tick();
    check("irq_vec", {6'd0, vec_sel}, 8'd3);
    check("irq_inst", inst, 8'h00);
    quiet(); irq_n = 0; iflag = 0; run(7);
    check("irq_done", {6'd0, vec_sel}, 8'd0);
    quiet(); din = 8'h60; tick();
    dec_last = 1; irq_n = 0; iflag = 1; tick();
    check("irq_masked", {6'd0, state}, 8'd1);

    // NMI pulse while stalled, then a competing IRQ.
    quiet(); din = 8'hA9; tick();
    rdy = 0; nmi_n = 0; tick();
    nmi_n = 1; tick();
    rdy = 1; dec_last = 1; irq_n = 0; iflag = 0; tick();
    quiet(); run(7);

    // Run off the end of the cycle counter, then recover via reset.
    quiet(); din = 8'h02; tick();
    run(7);
    check("halt_set", {7'd0, halt}, 8'd1);
    check("halt_cyc", {5'd0, cyc}, 8'd7);
    run(3);
    clr = 0; tick();
    check("halt_clr", {7'd0, halt}, 8'd0);

    // Reset in the middle of an interrupt sequence.
    boot_fetch(8'h11);
    dec_last = 1; irq_n = 0; iflag = 0; tick();
    quiet(); run(3);
    clr = 0; tick();
    check("int_abort", {6'd0, state}, 8'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      clr      = ($urandom_range(0, 59) != 0);
      rdy      = ($urandom_range(0, 4) != 0);
      din      = 8'($urandom);
      dec_last = ($urandom_range(0, 2) == 0);
      dec_skip = ($urandom_range(0, 3) == 0);
      irq_n    = ($urandom_range(0, 3) != 0);
      iflag    = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) nmi_n = ~nmi_n;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
